// File: rtl/galois_mult_arbiter_pkg.sv
// Shared definitions for the BN254 multiplier arbiter.
// Holds the BN254 scalar-field modulus, the Barrett constant derived from it,
// default widths/latency and the response tag carried alongside the multiplier.
package galois_mult_arbiter_pkg;

  localparam int N_BITS_DEF       = 254;
  localparam int MULT_LATENCY_DEF = 16;
  // Requester index width; covers up to 8 requesters.
  localparam int IDX_W            = 3;

  localparam logic [253:0] BN254_P =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  // Barrett constant mu = floor(2^(2k) / p) with k = 254; it fits in k+1 bits.
  localparam logic [508:0] BARRETT_POW = {1'b1, 508'd0};
  localparam logic [508:0] BN254_MU_W  = BARRETT_POW / {255'd0, BN254_P};
  localparam logic [254:0] BN254_MU    = BN254_MU_W[254:0];

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/galois_mult_barrett_sync.sv
// Fully pipelined a*b mod p over the BN254 scalar field, Barrett reduction.
// Ports: clk; a, b (254-bit operands, any value < 2^254); prod (a*b mod p),
// valid exactly LATENCY clocks after the operands. Accepts new operands
// every cycle and has no reset: results are qualified externally.
// Stages: 1 full product, 2 quotient estimate, 3 remainder (< 3p),
// 4 final two conditional subtractions, then pure delay up to LATENCY.
module galois_mult_barrett_sync
  import galois_mult_arbiter_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY_DEF   // must be >= 4
) (
  input  logic         clk,
  input  logic [253:0] a,
  input  logic [253:0] b,
  output logic [253:0] prod
);

  localparam logic [255:0] P_EXT = {2'b00, BN254_P};
  localparam int           DLY   = LATENCY - 3;

  logic [507:0] x_d, x_q;
  logic [254:0] q3_d, q3_q;
  logic [255:0] xlo_d, xlo_q;
  logic [255:0] r_d, r_q;
  logic [255:0] r1;
  logic [253:0] dly_d [DLY];
  logic [253:0] dly_q [DLY];

  always_comb begin
    x_d   = {254'd0, a} * {254'd0, b};
    // q3 = floor(floor(x / 2^(k-1)) * mu / 2^(k+1))
    q3_d  = 255'(({255'd0, x_q[507:253]} * {255'd0, BN254_MU}) >> 255);
    xlo_d = x_q[255:0];
    // True remainder is < 3p < 2^256, so arithmetic mod 2^256 is exact.
    r_d   = xlo_q - (256'(q3_q) * P_EXT);
    r1    = (r_q >= P_EXT) ? (r_q - P_EXT) : r_q;
    dly_d[0] = (r1 >= P_EXT) ? 254'(r1 - P_EXT) : 254'(r1);
    for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
  end

  always_ff @(posedge clk) begin
    x_q   <= x_d;
    q3_q  <= q3_d;
    xlo_q <= xlo_d;
    r_q   <= r_d;
    for (int i = 0; i < DLY; i++) dly_q[i] <= dly_d[i];
  end

  assign prod = dly_q[DLY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports: req (request vector), ptr (index granted last); gnt (one-hot grant,
// only ever on a requesting bit), gnt_idx (binary index of gnt, 0 when idle).
// Search starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter
  import galois_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % N_REQ);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/galois_mult_arbiter.sv
// Shares one pipelined BN254 modular multiplier among N_REQ requesters.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is a one-hot grant
//   req_a, req_b      packed operands, slice i = requester i
//   rsp_valid         one-hot response strobe (no backpressure)
//   rsp_data          shared product bus, valid only with rsp_valid
//   inflight_cnt      accepted operations not yet returned; idle when 0
//   issue_cnt         (GALOIS_MULT_ARB_STATS_EN only) per-requester saturating
//                     32-bit acceptance counters
// A tag (valid + requester index) travels beside the multiplier through a
// shift register of the same latency and steers the result on emergence.
// N_BITS must stay 254: the multiplier is fixed to the BN254 field.
module galois_mult_arbiter
  import galois_mult_arbiter_pkg::*;
#(
  parameter int N_BITS       = N_BITS_DEF,
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ*N_BITS-1:0]            req_a,
  input  logic [N_REQ*N_BITS-1:0]            req_b,
  output logic [N_REQ-1:0]                   rsp_valid,
  output logic [N_BITS-1:0]                  rsp_data,
  output logic [$clog2(MULT_LATENCY+1)-1:0]  inflight_cnt,
  output logic                               idle
`ifdef GALOIS_MULT_ARB_STATS_EN
  ,output logic [N_REQ*32-1:0]               issue_cnt
`endif
);

  localparam int CNT_W = $clog2(MULT_LATENCY+1);

  logic [IDX_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              accept;
  logic              emerge;
  logic [N_BITS-1:0] op_a, op_b;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  tag_t              tag_d [MULT_LATENCY];
  tag_t              tag_q [MULT_LATENCY];
  tag_t              tag_out;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  galois_mult_barrett_sync #(.LATENCY(MULT_LATENCY)) u_mult (
    .clk  (clk),
    .a    (op_a),
    .b    (op_b),
    .prod (rsp_data)
  );

  // Grant and operand steering; idle cycles feed zeros so the datapath
  // never sees stale operands.
  always_comb begin
    req_ready = rst ? '0 : gnt;
    accept    = |req_ready;
    op_a      = '0;
    op_b      = '0;
    if (accept) begin
      op_a = req_a[gnt_idx*N_BITS +: N_BITS];
      op_b = req_b[gnt_idx*N_BITS +: N_BITS];
    end
    last_d = accept ? gnt_idx : last_q;
  end

  always_comb begin
    tag_d[0].vld = accept;
    tag_d[0].idx = gnt_idx;
    for (int i = 1; i < MULT_LATENCY; i++) tag_d[i] = tag_q[i-1];
    tag_out = tag_q[MULT_LATENCY-1];
    emerge  = tag_out.vld && !rst;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = emerge && (tag_out.idx == IDX_W'(i));
    cnt_d        = cnt_q + CNT_W'(accept) - CNT_W'(emerge);
    inflight_cnt = rst ? '0 : cnt_q;
    idle         = (inflight_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDX_W'(N_REQ-1);
      cnt_q  <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < MULT_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

`ifdef GALOIS_MULT_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] issue_q, issue_d;

  always_comb begin
    issue_d = issue_q;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i] && (issue_q[i] != '1)) issue_d[i] = issue_q[i] + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) issue_q <= '0;
    else     issue_q <= issue_d;
  end

  assign issue_cnt = issue_q;
`endif

endmodule

// File: doc/galois_mult_arbiter.md
GALOIS_MULT_ARBITER -- requirements
Module: galois_mult_arbiter

Interface
REQ-001 Parameters, one per line: N_BITS, 254, operand/product width; N_REQ, 4, number of requesters (2..8); MULT_LATENCY, 16, cycles from operands applied to product valid.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  N_REQ  per-requester multiply request.
REQ-005 req_ready  output  N_REQ  one-hot grant; a request is accepted when valid & ready in the same cycle.
REQ-006 req_a  input  N_REQ*N_BITS  packed first operands; slice i belongs to requester i.
REQ-007 req_b  input  N_REQ*N_BITS  packed second operands.
REQ-008 rsp_valid  output  N_REQ  one-hot; bit i marks a product for requester i.
REQ-009 rsp_data  output  N_BITS  shared product bus; meaningful only when rsp_valid is nonzero.
REQ-010 inflight_cnt  output  $clog2(MULT_LATENCY+1)  number of accepted operations not yet returned.
REQ-011 idle  output  1  high when inflight_cnt is 0.

Function
REQ-012 The block SHALL share one fully pipelined modular multiplier (new operands every cycle, no stall) among N_REQ requesters.
REQ-013 Grant SHALL be round-robin: priority starts at (last_granted+1) mod N_REQ; at most one req_ready bit high per cycle.
REQ-014 req_ready SHALL be high only for the selected requester whose req_valid is high; no grant when all req_valid are low.
REQ-015 In the acceptance cycle, the granted requester's req_a/req_b SHALL drive the multiplier inputs; otherwise the inputs SHALL be driven to zero.
REQ-016 last_granted SHALL update only on acceptance.
REQ-017 A tag pipeline of depth MULT_LATENCY (valid bit plus requester index) SHALL shift every cycle; the entry pushed at acceptance SHALL emerge exactly MULT_LATENCY cycles later.
REQ-018 rsp_valid SHALL be the one-hot decode of the emerging tag; rsp_data SHALL equal the multiplier product in that cycle (a*b mod p, p = BN254 scalar modulus).
REQ-019 Responses have no backpressure; each requester SHALL accept rsp_valid in the cycle it is asserted.
REQ-020 Throughput SHALL be one accepted operation per cycle with a sustained request; ordering per requester SHALL be preserved.
REQ-021 inflight_cnt SHALL be +1 on acceptance only, -1 on emergence only, and unchanged on both or neither; maximum MULT_LATENCY.
REQ-022 A requester dropping req_valid before grant SHALL lose nothing; its priority position SHALL be unchanged.

Reset
REQ-023 While rst is high, req_ready, rsp_valid, inflight_cnt SHALL be 0, idle 1, all tag valid bits cleared, last_granted = N_REQ-1 (requester 0 first priority).
REQ-024 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL appear for them after reset.
REQ-025 The multiplier datapath is not reset; its outputs are qualified only by tag valid bits.

Configuration
REQ-026 With GALOIS_MULT_ARB_STATS_EN defined, the block SHALL add output issue_cnt (N_REQ*32): per-requester acceptance counters, saturating at 2^32-1 and cleared by rst.
REQ-027 Without GALOIS_MULT_ARB_STATS_EN, issue_cnt and its counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 The shared package SHALL hold the BN254 modulus constant, N_BITS, MULT_LATENCY defaults, and the tag struct typedef (valid, requester index).
REQ-029 The round-robin grant logic SHALL be a sub-module, rr_arbiter (request vector, pointer in; one-hot grant out); the multiplier SHALL be the existing galois_mult_barrett_sync instance.

Verification
REQ-030 Single request: requester 2 with a=3, b=5 -> req_ready[2] high that cycle; rsp_valid=4'b0100, rsp_data=15 exactly 16 cycles later; idle returns 1.
REQ-031 All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; eight responses in the same order from cycle 16 on, inflight_cnt peaking at 8.
REQ-032 Identity check: a=test_in1, b=1 and a=1, b=test_in2 on back-to-back cycles -> responses test_in1, then test_in2 on consecutive cycles.
REQ-033 rst asserted 5 cycles after 3 acceptances -> inflight_cnt=0, no rsp_valid for 20 following cycles, next request gets requester 0 priority.
REQ-034 Sustained single-requester stream for 40 cycles -> 40 responses, inflight_cnt steady at 16, product = a*b mod p for random operands.
REQ-035 With GALOIS_MULT_ARB_STATS_EN: 7 acceptances on requester 1 -> issue_cnt slice 1 = 7, others 0; rst clears all slices.
